// File: rtl/seq_gen_4bit_pkg.sv
// Shared definitions for the 4-bit symbol-sequence interface: FSM encoding,
// the default idle fill value, and the symbol constants of the detector.
package seq_gen_4bit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  localparam logic [3:0] IDLE_FILL_DEF = 4'hF;

  // Symbols the sequence detector looks for, in arrival order 1 -> 0 -> 2 -> 4.
  localparam logic [3:0]  DET_SYM0    = 4'h1;
  localparam logic [3:0]  DET_SYM1    = 4'h0;
  localparam logic [3:0]  DET_SYM2    = 4'h2;
  localparam logic [3:0]  DET_SYM3    = 4'h4;
  localparam logic [15:0] DET_PATTERN = {DET_SYM3, DET_SYM2, DET_SYM1, DET_SYM0};

  // Symbol k of a packed pattern lives in bits [4k+3:4k].
  function automatic logic [3:0] get_sym(input logic [15:0] seq, input logic [1:0] idx);
    logic [15:0] shifted;
    shifted = seq >> {idx, 2'b00};
    return shifted[3:0];
  endfunction

endpackage

// File: rtl/seq_gen_cnt.sv
// Loadable down-counter that saturates at zero; shared by the repeat and gap
// counters of the sequence generator.
module seq_gen_cnt #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         is_one_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Load has priority; decrement never wraps below zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign is_one_o = (cnt_q == W'(1));

endmodule

// File: rtl/seq_gen_4bit.sv
// Programmable 4-symbol sequence transmitter.
// Handshake: a symbol transfers on a rising edge where valid_o && ready_i;
// while ready_i is low in SEND, data_o/valid_o hold; valid_o never drops
// without a transfer. All outputs are registered.
module seq_gen_4bit
  import seq_gen_4bit_pkg::*;
#(
  parameter logic [3:0] IDLE_FILL = IDLE_FILL_DEF,
  parameter int         CNT_W     = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic [15:0]      seq_i,
  input  logic [CNT_W-1:0] repeat_i,
  input  logic [3:0]       gap_i,
  input  logic             ready_i,
  output logic [3:0]       data_o,
  output logic             valid_o,
  output logic             busy_o,
  output logic             done_o,
  output state_e           dbg_state_o
);

  state_e      state_q, state_d;
  logic [15:0] seq_q, seq_d;
  logic [3:0]  gap_q, gap_d;
  logic [1:0]  idx_q, idx_d;
  logic [3:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic             rep_load, rep_dec, rep_is_one;
  logic [CNT_W-1:0] rep_load_val;
  logic             gap_load, gap_dec, gap_is_one;

  seq_gen_cnt #(.W(CNT_W)) u_rep_cnt (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .load_i     (rep_load),
    .load_val_i (rep_load_val),
    .dec_i      (rep_dec),
    .is_one_o   (rep_is_one)
  );

  seq_gen_cnt #(.W(4)) u_gap_cnt (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .load_i     (gap_load),
    .load_val_i (gap_q),
    .dec_i      (gap_dec),
    .is_one_o   (gap_is_one)
  );

  // Next-state logic; outputs are derived from the next state so they register cleanly.
  always_comb begin
    state_d      = state_q;
    seq_d        = seq_q;
    gap_d        = gap_q;
    idx_d        = idx_q;
    done_d       = 1'b0;
    rep_load     = 1'b0;
    rep_load_val = '0;
    rep_dec      = 1'b0;
    gap_load     = 1'b0;
    gap_dec      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // The done cycle already shows IDLE, but a start there must not be taken.
        if (start_i && !done_q) begin
          seq_d        = seq_i;
          gap_d        = gap_i;
          rep_load     = 1'b1;
          rep_load_val = (repeat_i == '0) ? CNT_W'(1) : repeat_i;
          idx_d        = 2'd0;
          state_d      = ST_SEND;
        end
      end
      ST_SEND: begin
        if (ready_i) begin
          if (idx_q == 2'd3) begin
            idx_d = 2'd0;
            if (rep_is_one) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end else begin
              rep_dec = 1'b1;
              if (gap_q != 4'd0) begin
                gap_load = 1'b1;
                state_d  = ST_GAP;
              end
            end
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      ST_GAP: begin
        if (gap_is_one) state_d = ST_SEND;
        else            gap_dec = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    valid_d = (state_d == ST_SEND);
    data_d  = valid_d ? get_sym(seq_d, idx_d) : IDLE_FILL;
    busy_d  = (state_d != ST_IDLE) || done_d;
  end

  // State, latched configuration and registered outputs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      seq_q   <= '0;
      gap_q   <= '0;
      idx_q   <= '0;
      data_q  <= IDLE_FILL;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      seq_q   <= seq_d;
      gap_q   <= gap_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_seq_gen_4bit.sv
// Directed testbench for seq_gen_4bit.
module tb_seq_gen_4bit;
  import seq_gen_4bit_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        start_i = 1'b0;
  logic [15:0] seq_i = '0;
  logic [7:0]  repeat_i = '0;
  logic [3:0]  gap_i = '0;
  logic        ready_i = 1'b1;
  logic [3:0]  data_o;
  logic        valid_o;
  logic        busy_o;
  logic        done_o;
  state_e      dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [4:0] exp_q[$];

  // Loopback detector model: last four accepted symbols, oldest in the top nibble.
  logic [15:0] hist = '0;
  bit          lb_en = 1'b0;
  int          found_cyc[$];

  seq_gen_4bit dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .start_i     (start_i),
    .seq_i       (seq_i),
    .repeat_i    (repeat_i),
    .gap_i       (gap_i),
    .ready_i     (ready_i),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .dbg_state_o (dbg_state)
  );

  // Clock and cycle counter.
  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc++;

  // Detector model fed from the DUT output stream.
  always @(posedge clk_i) begin
    if (valid_o && ready_i) begin
      hist = {hist[11:0], data_o};
      if (lb_en && hist == 16'h1024) found_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, " valid"}, 32'(valid_o), 32'h0);
    check({tag, " data"},  32'(data_o),  32'hF);
    check({tag, " busy"},  32'(busy_o),  32'h0);
    check({tag, " done"},  32'(done_o),  32'h0);
  endtask

  // Expected per-cycle {valid,data} for a run with ready held high.
  task automatic build_exp(input logic [15:0] seq, input int rep, input int gap);
    exp_q.delete();
    for (int r = 0; r < rep; r++) begin
      for (int k = 0; k < 4; k++) exp_q.push_back({1'b1, seq[4*k +: 4]});
      if (r < rep - 1)
        for (int g = 0; g < gap; g++) exp_q.push_back(5'h0F);
    end
  endtask

  // Start a run at a negedge and check every cycle until done_o (bounded).
  task automatic run_stream(input string tag, input logic [15:0] seq, input int drv_rep,
                            input int gap, input int exp_rep, input int exp_len,
                            input bit disturb);
    int n;
    logic [4:0] e;
    build_exp(seq, exp_rep, gap);
    seq_i    = seq;
    repeat_i = drv_rep[7:0];
    gap_i    = gap[3:0];
    ready_i  = 1'b1;
    start_i  = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    n = 0;
    while (!done_o && n < exp_len + 20) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 5'h00;
      check({tag, " sym"},  32'({valid_o, data_o}), 32'(e));
      check({tag, " busy"}, 32'(busy_o), 32'h1);
      if (disturb && n == 1) begin
        start_i  = 1'b1;
        seq_i    = ~seq;
        repeat_i = 8'd5;
        gap_i    = 4'd7;
      end else if (disturb && n == 2) begin
        start_i = 1'b0;
      end
      n++;
      @(negedge clk_i);
    end
    check({tag, " len"},        32'(n),       32'(exp_len));
    check({tag, " done"},       32'(done_o),  32'h1);
    check({tag, " done valid"}, 32'(valid_o), 32'h0);
    check({tag, " done data"},  32'(data_o),  32'hF);
    check({tag, " done busy"},  32'(busy_o),  32'h1);
    if (disturb) start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    check_idle({tag, " after"});
  endtask

  int bp_data[7] = '{1, 0, 2, 2, 2, 2, 4};
  bit bp_rdy[7]  = '{1, 1, 0, 0, 0, 1, 1};

  initial begin
    // Reset
    repeat (2) @(negedge clk_i);
    check_idle("reset");
    check("reset state", 32'(dbg_state), 32'(ST_IDLE));
    rst_n_i = 1'b1;
    @(negedge clk_i);
    check_idle("idle no start");

    // Basic: 1,0,2,4 then done
    run_stream("basic", 16'h4201, 1, 0, 1, 4, 1'b0);

    // Repeat with gap: 4*3 + 2*2 = 16 cycles
    run_stream("rep3gap2", 16'h4201, 3, 2, 3, 16, 1'b0);

    // Repeat 0 behaves as 1
    run_stream("rep0", 16'h9C35, 0, 5, 1, 4, 1'b0);

    // Ignored start / input changes while busy and in the done cycle
    run_stream("ignore", 16'h4201, 2, 1, 2, 9, 1'b1);

    // Large repeat count
    run_stream("rep255", 16'h7E18, 255, 0, 255, 1020, 1'b0);

    // Backpressure: symbol 2 held 4 cycles, done 3 cycles late
    seq_i = 16'h4201; repeat_i = 8'd1; gap_i = 4'd0; ready_i = 1'b1; start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    for (int i = 0; i < 7; i++) begin
      ready_i = bp_rdy[i];
      check("bp valid", 32'(valid_o), 32'h1);
      check("bp data",  32'(data_o),  32'(bp_data[i]));
      @(negedge clk_i);
    end
    check("bp done", 32'(done_o), 32'h1);
    check("bp busy", 32'(busy_o), 32'h1);
    @(negedge clk_i);
    check_idle("bp after");

    // Reset during the second symbol
    seq_i = 16'h4201; repeat_i = 8'd3; gap_i = 4'd0; start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    @(negedge clk_i);
    check("rst pre data", 32'(data_o), 32'h0);
    #2 rst_n_i = 1'b0;
    #1 check_idle("rst async");
    @(negedge clk_i);
    rst_n_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check_idle("rst stays idle");
    end
    run_stream("post rst", 16'h4201, 1, 0, 1, 4, 1'b0);

    // Loopback into detector model
    found_cyc.delete();
    lb_en = 1'b1;
    run_stream("loop", 16'h4201, 2, 0, 2, 8, 1'b0);
    lb_en = 1'b0;
    check("loop found count", 32'(found_cyc.size()), 32'd2);
    if (found_cyc.size() == 2)
      check("loop spacing", 32'(found_cyc[1] - found_cyc[0]), 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
